// File: rtl/bcd_encoder_arbiter_pkg.sv
// Shared types and width helpers for the round-robin BCD encoder arbiter.
package bcd_encoder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int unsigned bcd_width(input int unsigned n);
    return n + (n - 4) / 3 + 1;
  endfunction

  function automatic int unsigned id_width(input int unsigned r);
    return ($clog2(r) > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/bcd_encoder.sv
// Combinational binary-to-BCD converter (shift-and-add-3).
module bcd_encoder
  import bcd_encoder_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned BW = bcd_width(N)
) (
  input  logic [N-1:0]  i_bin,
  output logic [BW-1:0] o_bcd
);

  localparam int unsigned SW = BW + N + 4;
  localparam int unsigned ND = (BW + 3) / 4;

  logic [SW-1:0] scratch;

  // Digits sit above the binary field; each step corrects digits >= 5 then shifts.
  always_comb begin
    scratch = '0;
    scratch[N-1:0] = i_bin;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned d = 0; d < ND; d++) begin
        if (scratch[N + 4*d +: 4] >= 4'd5) begin
          scratch[N + 4*d +: 4] = scratch[N + 4*d +: 4] + 4'd3;
        end
      end
      scratch = scratch << 1;
    end
    o_bcd = scratch[N +: BW];
  end

endmodule

// File: rtl/bcd_rr_arbiter.sv
// Round-robin one-hot grant; the pointer moves past the winner on i_advance.
module bcd_rr_arbiter
  import bcd_encoder_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = id_width(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_any
);

  logic [IDW-1:0] ptr;
  int unsigned    idx;

  // Search upward from the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    idx        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!o_any && i_req[IDW'(idx)]) begin
        o_any                = 1'b1;
        o_grant[IDW'(idx)]   = 1'b1;
        o_grant_id           = IDW'(idx);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
    end else if (i_advance) begin
      ptr <= (o_grant_id == IDW'(NUM_REQ - 1)) ? '0 : o_grant_id + IDW'(1);
    end
  end

endmodule

// File: rtl/bcd_encoder_arbiter.sv
// Shares one bcd_encoder among NUM_REQ requesters with round-robin grants.
// Define BCD_ENCODER_ARBITER_BACK_TO_BACK_EN to also arbitrate while a response is being accepted.
module bcd_encoder_arbiter
  import bcd_encoder_arbiter_pkg::*;
#(
  parameter  int unsigned N       = 8,
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned BW      = bcd_width(N),
  localparam int unsigned IDW     = id_width(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [NUM_REQ*N-1:0] i_req_bin,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [BW-1:0]        o_rsp_bcd,
  output logic [IDW-1:0]       o_rsp_id
);

  state_t             state;
  logic [N-1:0]       operand;
  logic [IDW-1:0]     id;
  logic [BW-1:0]      enc_bcd;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               grant_any;
  logic               arb_en;
  logic               handshake;
  logic [N-1:0]       sel_bin;

`ifdef BCD_ENCODER_ARBITER_BACK_TO_BACK_EN
  assign arb_en = !i_rst && ((state == IDLE) || ((state == RESP) && i_rsp_ready));
`else
  assign arb_en = !i_rst && (state == IDLE);
`endif

  assign o_req_ready = arb_en ? grant : '0;
  assign handshake   = arb_en && grant_any;

  bcd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req_valid),
    .i_advance  (handshake),
    .o_grant    (grant),
    .o_grant_id (grant_id),
    .o_any      (grant_any)
  );

  bcd_encoder #(.N(N)) u_enc (
    .i_bin (operand),
    .o_bcd (enc_bcd)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_bin = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) sel_bin = i_req_bin[k*N +: N];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      operand     <= '0;
      id          <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_bcd   <= '0;
      o_rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            operand <= sel_bin;
            id      <= grant_id;
            state   <= CONV;
          end
        end
        CONV: begin
          o_rsp_bcd   <= enc_bcd;
          o_rsp_id    <= id;
          o_rsp_valid <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            // handshake can only be high here when back-to-back arbitration is built in
            if (handshake) begin
              operand <= sel_bin;
              id      <= grant_id;
              state   <= CONV;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_encoder_arbiter.sv
// Scoreboard bench for bcd_encoder_arbiter: arbitration model plus expected-response queue.
module tb_bcd_encoder_arbiter;

  localparam int unsigned N   = 8;
  localparam int unsigned NR  = 4;
  localparam int unsigned BW  = 10;
  localparam int unsigned IDW = 2;
`ifdef BCD_ENCODER_ARBITER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] i_req_valid;
  logic [NR-1:0] o_req_ready;
  logic [NR*N-1:0] i_req_bin;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [BW-1:0] o_rsp_bcd;
  logic [IDW-1:0] o_rsp_id;

  always #5 clk = ~clk;

  bcd_encoder_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_bin   (i_req_bin),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_bcd   (o_rsp_bcd),
    .o_rsp_id    (o_rsp_id)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [BW-1:0]  bcd;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   resp_log[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   ptr_m = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   t;
    r = '0;
    t = v;
    for (int d = 0; d < 3; d++) begin
      r = r | BW'((t % 10) << (4 * d));
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) begin
      if (v[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: check responses against the queue, then predict this cycle's grant.
  always @(negedge clk) begin
    exp_t          e;
    int            k;
    logic [NR-1:0] want;
    if (rst) begin
      exp_q.delete();
      ptr_m = 0;
      prev_valid = 1'b0;
    end else begin
      if (o_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(o_rsp_valid), 64'(0));
        end else begin
          e = exp_q[0];
          if (!prev_valid) check("rsp_latency", 64'(cyc), 64'(e.cyc));
          check("rsp_id", 64'(o_rsp_id), 64'(e.id));
          check("rsp_bcd", 64'(o_rsp_bcd), 64'(e.bcd));
          if (i_rsp_ready) begin
            void'(exp_q.pop_front());
            resp_log.push_back(cyc);
          end
        end
      end
      prev_valid = o_rsp_valid;

      k = rr_pick(i_req_valid, ptr_m);
      if (exp_q.size() != 0 || k < 0) want = '0;
      else if (o_rsp_valid && i_rsp_ready) want = B2B ? (NR'(1) << k) : '0;
      else if (o_rsp_valid) want = '0;
      else want = NR'(1) << k;
      check("req_ready", 64'(o_req_ready), 64'(want));

      if (want != '0) begin
        e.id  = IDW'(k);
        e.bcd = to_bcd(32'(i_req_bin[k*N +: N]));
        e.cyc = cyc + 2;
        exp_q.push_back(e);
        grant_log.push_back(k);
        ptr_m = (k + 1) % NR;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int k);
    #1;
    for (int n = 0; n < 30; n++) begin
      if (o_req_ready[k]) begin
        step();
        i_req_valid[k] = 1'b0;
        return;
      end
      step();
    end
    check("grant_timeout", 64'(o_req_ready[k]), 64'(1));
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (exp_q.size() == 0 && !o_rsp_valid) return;
      step();
    end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    rst = 1'b1;
    i_req_valid = '0;
    i_req_bin = '0;
    i_rsp_ready = 1'b0;
    step();
    step();
    check("rst_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_bcd", 64'(o_rsp_bcd), 64'(0));
    check("rst_id", 64'(o_rsp_id), 64'(0));
    check("rst_ready", 64'(o_req_ready), 64'(0));
    rst = 1'b0;
    step();

    // Single request; operand changed right after the handshake.
    i_rsp_ready = 1'b1;
    i_req_bin[2*N +: N] = 8'd255;
    i_req_valid[2] = 1'b1;
    wait_grant(2);
    i_req_bin[2*N +: N] = 8'd0;
    drain();
    check("single_resp_count", 64'(resp_log.size()), 64'(1));

    // All requesters valid: grants rotate 0,1,2,3,...
    do_reset();
    grant_log.delete();
    i_req_bin = {8'd99, 8'd10, 8'd9, 8'd0};
    i_req_valid = 4'hF;
    for (int n = 0; n < 80 && grant_log.size() < 8; n++) step();
    i_req_valid = '0;
    drain();
    check("rr_count", 64'(grant_log.size() >= 8), 64'(1));
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(i % 4));
    end

    // Backpressure with other requesters pending.
    do_reset();
    i_rsp_ready = 1'b0;
    i_req_bin = {8'd42, 8'd0, 8'd128, 8'd7};
    i_req_valid[1] = 1'b1;
    wait_grant(1);
    i_req_valid[0] = 1'b1;
    i_req_valid[3] = 1'b1;
    for (int n = 0; n < 10 && !o_rsp_valid; n++) step();
    for (int n = 0; n < 5; n++) begin
      check("bp_valid", 64'(o_rsp_valid), 64'(1));
      check("bp_bcd", 64'(o_rsp_bcd), 64'h128);
      check("bp_ready", 64'(o_req_ready), 64'(0));
      step();
    end
    i_rsp_ready = 1'b1;
    wait_grant(3);
    wait_grant(0);
    drain();

    // Asynchronous reset while converting.
    i_req_bin[2*N +: N] = 8'd37;
    i_req_valid[2] = 1'b1;
    wait_grant(2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(o_rsp_valid), 64'(0));
    check("mid_rst_bcd", 64'(o_rsp_bcd), 64'(0));
    check("mid_rst_id", 64'(o_rsp_id), 64'(0));
    check("mid_rst_ready", 64'(o_req_ready), 64'(0));
    step();
    step();
    rst = 1'b0;
    grant_log.delete();
    i_req_bin[0 +: N] = 8'd5;
    i_req_bin[3*N +: N] = 8'd66;
    i_req_valid[0] = 1'b1;
    i_req_valid[3] = 1'b1;
    #1;
    check("post_rst_grant", 64'(o_req_ready), 64'b0001);
    wait_grant(0);
    wait_grant(3);
    drain();

    // Pointer at 2, requesters 3 and 1 valid; requester 0 withdraws before arbitration.
    do_reset();
    i_rsp_ready = 1'b0;
    i_req_bin = {8'd200, 8'd0, 8'd13, 8'd0};
    i_req_valid[1] = 1'b1;
    wait_grant(1);
    i_req_valid[0] = 1'b1;
    step();
    step();
    i_req_valid[0] = 1'b0;
    i_req_valid[3] = 1'b1;
    i_req_valid[1] = 1'b1;
    grant_log.delete();
    i_rsp_ready = 1'b1;
    wait_grant(3);
    wait_grant(1);
    drain();
    check("skip_count", 64'(grant_log.size()), 64'(2));
    if (grant_log.size() >= 2) begin
      check("skip_first", 64'(grant_log[0]), 64'(3));
      check("skip_second", 64'(grant_log[1]), 64'(1));
    end

    // Sustained throughput with two requesters.
    do_reset();
    resp_log.delete();
    i_req_bin = {8'd0, 8'd0, 8'd51, 8'd50};
    i_req_valid = 4'b0011;
    for (int n = 0; n < 60 && resp_log.size() < 5; n++) step();
    i_req_valid = '0;
    drain();
    gap = B2B ? 2 : 3;
    check("tput_count", 64'(resp_log.size() >= 5), 64'(1));
    for (int i = 1; i < 5 && i < resp_log.size(); i++) begin
      check($sformatf("tput_gap%0d", i), 64'(resp_log[i] - resp_log[i-1]), 64'(gap));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
